// File: rtl/hex7seg_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | hex7seg_pkg : glyph table and decode function for active-low 7-seg lines  |
// | rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
package hex7seg_pkg;

  localparam int SEG_A = 0;
  localparam int SEG_B = 1;
  localparam int SEG_C = 2;
  localparam int SEG_D = 3;
  localparam int SEG_E = 4;
  localparam int SEG_F_BIT = 5;
  localparam int SEG_G = 6;
  localparam int SEG_W = SEG_G + 1;

  localparam logic [SEG_W-1:0] SEG_0     = 7'h40;
  localparam logic [SEG_W-1:0] SEG_1     = 7'h79;
  localparam logic [SEG_W-1:0] SEG_2     = 7'h24;
  localparam logic [SEG_W-1:0] SEG_3     = 7'h30;
  localparam logic [SEG_W-1:0] SEG_4     = 7'h19;
  localparam logic [SEG_W-1:0] SEG_5     = 7'h12;
  localparam logic [SEG_W-1:0] SEG_6     = 7'h02;
  localparam logic [SEG_W-1:0] SEG_7     = 7'h78;
  localparam logic [SEG_W-1:0] SEG_8     = 7'h00;
  localparam logic [SEG_W-1:0] SEG_9     = 7'h10;
  localparam logic [SEG_W-1:0] SEG_A_GLY = 7'h08;
  localparam logic [SEG_W-1:0] SEG_B_GLY = 7'h03;
  localparam logic [SEG_W-1:0] SEG_C_GLY = 7'h46;
  localparam logic [SEG_W-1:0] SEG_D_GLY = 7'h21;
  localparam logic [SEG_W-1:0] SEG_E_GLY = 7'h06;
  localparam logic [SEG_W-1:0] SEG_F     = 7'h0E;
  localparam logic [SEG_W-1:0] SEG_BLANK = 7'h7F;

  typedef struct packed {
    logic [3:0] nibble;
    logic       blank;
    logic       err;
  } seg_dec_t;

  typedef enum logic [0:0] {
    SETTLE = 1'b0,
    STABLE = 1'b1
  } mon_state_t;

  // Blank and error digits both read as nibble 0; only the flags differ.
  function automatic seg_dec_t decode_glyph(input logic [SEG_W-1:0] seg);
    seg_dec_t d;
    d = '{nibble: 4'h0, blank: 1'b0, err: 1'b0};
    case (seg)
      SEG_0:     d.nibble = 4'h0;
      SEG_1:     d.nibble = 4'h1;
      SEG_2:     d.nibble = 4'h2;
      SEG_3:     d.nibble = 4'h3;
      SEG_4:     d.nibble = 4'h4;
      SEG_5:     d.nibble = 4'h5;
      SEG_6:     d.nibble = 4'h6;
      SEG_7:     d.nibble = 4'h7;
      SEG_8:     d.nibble = 4'h8;
      SEG_9:     d.nibble = 4'h9;
      SEG_A_GLY: d.nibble = 4'hA;
      SEG_B_GLY: d.nibble = 4'hB;
      SEG_C_GLY: d.nibble = 4'hC;
      SEG_D_GLY: d.nibble = 4'hD;
      SEG_E_GLY: d.nibble = 4'hE;
      SEG_F:     d.nibble = 4'hF;
      SEG_BLANK: d.blank  = 1'b1;
      default:   d.err    = 1'b1;
    endcase
    return d;
  endfunction

endpackage
`default_nettype wire

// File: rtl/hex_display_monitor_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | hex_display_monitor_if : segment inputs and decoded-result outputs       |
// | rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
interface hex_display_monitor_if #(
  parameter int CNT_W = 16
);
  logic [6:0]       hex0, hex1, hex2, hex3, hex4, hex5, hex6, hex7;
  logic [31:0]      value;
  logic [7:0]       blank_mask;
  logic [7:0]       err_mask;
  logic             value_valid;
  logic             stable;
  logic [CNT_W-1:0] update_count;

  modport master (
    output hex0, hex1, hex2, hex3, hex4, hex5, hex6, hex7,
    input  value, blank_mask, err_mask, value_valid, stable, update_count
  );

  modport slave (
    input  hex0, hex1, hex2, hex3, hex4, hex5, hex6, hex7,
    output value, blank_mask, err_mask, value_valid, stable, update_count
  );
endinterface
`default_nettype wire

// File: rtl/hex_display_monitor_seg7_decode.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | seg7_decode : combinational single-digit glyph decoder                   |
// | rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module seg7_decode
  import hex7seg_pkg::*;
(
  input  wire [SEG_W-1:0] i_seg,
  output logic [3:0]      o_nibble,
  output logic            o_blank,
  output logic            o_err
);
  seg_dec_t w_dec;

  always_comb w_dec = decode_glyph(i_seg);

  assign o_nibble = w_dec.nibble;
  assign o_blank  = w_dec.blank;
  assign o_err    = w_dec.err;
endmodule
`default_nettype wire

// File: rtl/hex_display_monitor.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | hex_display_monitor : debounced decode of eight 7-seg digits to 32 bits  |
// | rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module hex_display_monitor
  import hex7seg_pkg::*;
#(
  parameter int STABLE_CYCLES = 4,
  parameter int CNT_W         = 16
)(
  input wire                   clock,
  input wire                   reset,
  hex_display_monitor_if.slave bus
);
  // Run value seen on the edge that completes STABLE_CYCLES identical samples.
  localparam logic [7:0] c_RUN_MAX    = 8'(STABLE_CYCLES - 1);
  localparam logic [7:0] c_RUN_COMMIT = 8'(STABLE_CYCLES - 2);

  logic [55:0]      w_in;
  logic [31:0]      w_dec_value;
  logic [7:0]       w_dec_blank;
  logic [7:0]       w_dec_err;
  logic             w_match;
  logic             w_commit;
  logic             w_changed;
  mon_state_t       w_state_nxt;

  logic [55:0]      r_samp;
  logic [7:0]       r_run;
  mon_state_t       r_state;
  logic [31:0]      r_value;
  logic [7:0]       r_blank;
  logic [7:0]       r_err;
  logic             r_valid;
  logic [CNT_W-1:0] r_count;

  assign w_in = {bus.hex7, bus.hex6, bus.hex5, bus.hex4,
                 bus.hex3, bus.hex2, bus.hex1, bus.hex0};

  generate
    for (genvar gi = 0; gi < 8; gi++) begin : g_digit
      seg7_decode u_dec (
        .i_seg    (w_in[7*gi +: 7]),
        .o_nibble (w_dec_value[4*gi +: 4]),
        .o_blank  (w_dec_blank[gi]),
        .o_err    (w_dec_err[gi])
      );
    end
  endgenerate

  assign w_match   = (w_in == r_samp);
  assign w_commit  = w_match && (r_run == c_RUN_COMMIT);
  assign w_changed = ({w_dec_value, w_dec_blank, w_dec_err} != {r_value, r_blank, r_err});

  always_ff @(posedge clock) begin
    if (reset) begin
      r_samp <= {8{SEG_BLANK}};
      r_run  <= '0;
    end else begin
      r_samp <= w_in;
      if (!w_match)
        r_run <= '0;
      else if (r_run != c_RUN_MAX)
        r_run <= r_run + 8'd1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) r_state <= SETTLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    if (!w_match)
      w_state_nxt = SETTLE;
    else if (w_commit)
      w_state_nxt = STABLE;
  end

  // A re-qualified identical pattern commits silently: no pulse, no count.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_value <= '0;
      r_blank <= 8'hFF;
      r_err   <= '0;
      r_valid <= 1'b0;
      r_count <= '0;
    end else begin
      r_valid <= 1'b0;
      if (w_commit && w_changed) begin
        r_value <= w_dec_value;
        r_blank <= w_dec_blank;
        r_err   <= w_dec_err;
        r_valid <= 1'b1;
        r_count <= r_count + 1'b1;
      end
    end
  end

  assign bus.value        = r_value;
  assign bus.blank_mask   = r_blank;
  assign bus.err_mask     = r_err;
  assign bus.value_valid  = r_valid;
  assign bus.stable       = (r_state == STABLE);
  assign bus.update_count = r_count;
endmodule
`default_nettype wire

// File: doc/hex_display_monitor.md
Name: hex_display_monitor

Overview:
Observer on the processor's eight seven-segment outputs (HEX0..HEX7). It decodes the displayed glyphs back into a 32-bit hex value, filters out transient patterns, and publishes each newly stabilised value with a one-cycle strobe. It is the decoding end of the board display path. It is used in simulation benches and on-board self-check logic to read processor results without probing internal registers.

Parameters:
STABLE_CYCLES, 4, consecutive identical samples required before commit; legal range 2..255.
CNT_W, 16, width of update_count.

Ports:
clock  input  1  system clock; all state updates on rising edge
reset  input  1  synchronous, active-high
hex0..hex7  input  7 each  segment lines, active-low; bit0=a … bit6=g; hex0 = least-significant nibble
value  output  32  last committed decoded value; nibble i from hex i
blank_mask  output  8  bit i set = digit i blank (7'h7F) in committed value; nibble reads 0
err_mask  output  8  bit i set = digit i showed an unrecognised pattern; nibble reads 0
value_valid  output  1  one-cycle pulse on each commit
stable  output  1  high while the sampled inputs equal the committed pattern
update_count  output  CNT_W  number of commits since reset; wraps modulo 2^CNT_W

Behaviour:
- Reset, synchronous, wins over everything: value=0, blank_mask=8'hFF, err_mask=0, value_valid=0, stable=0, update_count=0. Internal sample register = all 7'h7F. Run counter = 0. FSM enters SETTLE.
- Glyph table, active-low:
  - 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78
  - 8=00, 9=10, A=08, b=03, C=46, d=21, E=06, F=0E
  - blank=7F
  - any other pattern is an error.
- Sampling: the 56-bit input vector is registered on every edge into samp.
- Run counter:
  - Cleared to 0 when the input differs from samp.
  - Otherwise incremented, saturating at STABLE_CYCLES-1.
- Commit condition: the input is sampled identically on STABLE_CYCLES consecutive edges. Example: it first appears at edge E and holds through edge E+STABLE_CYCLES-1.
- At the commit edge:
  - If the decoded {value, blank_mask, err_mask} differs from the registered outputs, update all three, pulse value_valid for exactly that one cycle, and increment update_count.
  - If it is equal, there is no pulse and no increment.
- FSM states:
  - SETTLE: the input is changing or the run is incomplete. stable=0.
  - STABLE: entered at the commit edge. stable=1.
  - Any edge where input ≠ samp returns the FSM to SETTLE, with stable=0 from that edge. value, blank_mask and err_mask hold their last committed contents.
- While in STABLE, no further pulses occur. A glitch shorter than STABLE_CYCLES edges produces no commit. After the glitch, the original pattern must re-qualify for the full STABLE_CYCLES. It then re-commits silently because the decoded contents are equal.
- value_valid never asserts in two consecutive cycles. Reaching that would need two different patterns committing back-to-back, which is impossible when STABLE_CYCLES≥2.
- Mixed digits are decoded independently: some blank, some error, some valid.
- Reset asserted mid-run discards the partial run. The first post-reset commit of a non-blank pattern always pulses.
- update_count at max wraps to 0 on the next commit.

Decomposition:
- Package hex7seg_pkg holds:
  - the 16 glyph constants plus SEG_BLANK;
  - the segment bit-order constants;
  - a function returning the {nibble, blank, err} triple.
- Sub-module seg7_decode: purely combinational, 7-bit in → 4-bit nibble, blank, err. Instantiated 8× inside hex_display_monitor.
- Counter, FSM and output registers live in the top.

Test Plan:
- Reset → outputs: value=0, blank_mask=FF, err_mask=0, value_valid=0, stable=0, update_count=0.
- Reset, then hold all hex=7F → no value_valid pulse, stable=1 after 4 edges.
- Drive hex7..hex0 = 12,19,30,24,79,40,08,0E ("54321 0AF") from edge 10 → value_valid high only in the cycle after edge 13. value=32'h54321_0AF with nibbles 5,4,3,2,1,0,A,F. blank_mask=0, update_count=1.
- Hold that value, then glitch hex0 to 00 for 2 cycles and restore → no value_valid pulse. stable low during the glitch and high again 4 edges after restore. update_count stays 1.
- Set hex3=7F and hex5=55, hold 4 edges → value_valid pulses once. blank_mask=08, err_mask=20, nibbles 3 and 5 read 0, update_count=2.
- Assert reset two edges into a qualifying run of a new pattern → outputs return to reset values with no pulse. The same pattern held afterwards commits 4 edges after reset release with update_count=1.
